// File: rtl/load_store_unit.sv
// Load/store unit: one byte-addressed request at a time against a word-wide memory
// with combinational read; sub-word stores are done as read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE (and not in reset). Every accepted request
// produces exactly one single-cycle resp_valid pulse unless reset intervenes.
module load_store_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_WORDS_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [2:0]            funct3_q;
   logic                  we_q;
   logic                  err_q;
   logic                  resp_valid_q;

   logic                  misaligned;
   logic                  out_of_range;
   logic                  illegal;
   logic                  req_err;
   logic [7:0]            lane_byte;
   logic [15:0]           lane_half;
   logic [DATA_WIDTH-1:0] load_val;
   logic [3:0]            byte_en;
   logic [DATA_WIDTH-1:0] store_data;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      out_of_range = |req_addr[DATA_WIDTH-1:MEM_WORDS_LOG2+2];
      if (req_we)
         illegal = (req_funct3 > 3'd2);
      else
         illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      req_err = misaligned || out_of_range || illegal;
   end

   // Load lane extraction works directly on the live memory read in READ.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    lane_byte = mem_rd[7:0];
         2'd1:    lane_byte = mem_rd[15:8];
         2'd2:    lane_byte = mem_rd[23:16];
         default: lane_byte = mem_rd[31:24];
      endcase
      lane_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (funct3_q)
         3'd0:    load_val = {{24{lane_byte[7]}}, lane_byte};
         3'd1:    load_val = {{16{lane_half[15]}}, lane_half};
         3'd2:    load_val = mem_rd;
         3'd4:    load_val = {24'd0, lane_byte};
         3'd5:    load_val = {16'd0, lane_half};
         default: load_val = '0;
      endcase
   end

   // Store merge: replicate the sub-word across lanes, then pick by byte enable.
   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            byte_en    = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            byte_en    = 4'b0011 << addr_q[1:0];
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_data = wdata_q;
         end
      endcase
      merged = rd_q;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i])
            merged[8*i +: 8] = store_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
         result_q     <= '0;
         funct3_q     <= 3'd0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               if (req_valid) begin
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  funct3_q <= req_funct3;
                  we_q     <= req_we;
                  err_q    <= req_err;
                  result_q <= '0;
                  if (req_err) begin
                     state        <= S_RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               rd_q <= mem_rd;
               if (we_q) begin
                  state <= S_WRITE;
               end else begin
                  result_q     <= load_val;
                  state        <= S_RESP;
                  resp_valid_q <= 1'b1;
               end
            end
            S_WRITE: begin
               state        <= S_RESP;
               resp_valid_q <= 1'b1;
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == S_IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = result_q;
   assign resp_err   = err_q;
   assign mem_we     = (state == S_WRITE) && !rst;
   assign mem_addr   = {2'b00, addr_q[DATA_WIDTH-1:2]};
   assign mem_wd     = (state == S_WRITE) ? merged : '0;
   assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-WRITE sequence and
// random traffic checked against a byte-array reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [1024];
   logic [7:0]  ref_b [4096];

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .MEM_WORDS_LOG2(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .dbg_state(dbg_state)
   );

   assign mem_rd = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wd;

   typedef struct {
      logic        pre;
      int          pre_idx;
      logic [31:0] pre_val;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          mem_idx;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vt [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request and observe it up to its response (bounded).
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int wecnt);
      int w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 0; wecnt = 0; rdata = 32'hX; err = 1'bX;
      for (int c = 1; c <= 8; c++) begin
         if (mem_we) wecnt++;
         if (resp_valid) begin
            lat   = c;
            rdata = resp_rdata;
            err   = resp_err;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Reference: byte-addressed memory, RISC-V load/store semantics.
   function automatic void ref_access(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err,
                                      output int lat);
      int size;
      logic [31:0] v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err = 1'b0;
      if (we && f3 > 3'd2) err = 1'b1;
      if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
      if (addr % size != 0) err = 1'b1;
      if (addr >= 32'd4096) err = 1'b1;
      rdata = 32'd0;
      if (err) begin
         lat = 1;
      end else if (we) begin
         for (int i = 0; i < size; i++) ref_b[int'(addr) + i] = 8'(wdata >> (8 * i));
         lat = 3;
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_b[int'(addr) + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
         rdata = v;
         lat = 2;
      end
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata, erd, w;
      logic        err, eerr;
      int          lat, elat, wecnt, seen;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;

      vt[0]  = '{1'b1, 4,    32'hDEADBEEF, 1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 4,    32'hDEADBEEF};
      vt[1]  = '{1'b1, 4,    32'h80FF1234, 1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 2, 4,    32'h80FF1234};
      vt[2]  = '{1'b0, 0,    32'h0,        1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0, 2, 4,    32'h80FF1234};
      vt[3]  = '{1'b1, 4,    32'h11223344, 1'b1, 3'd0, 32'h11,  32'h123456AA, 32'h0,        1'b0, 3, 4,    32'h1122AA44};
      vt[4]  = '{1'b1, 4,    32'h11223344, 1'b1, 3'd1, 32'h12,  32'h0000BEEF, 32'h0,        1'b0, 3, 4,    32'hBEEF3344};
      vt[5]  = '{1'b0, 0,    32'h0,        1'b0, 3'd5, 32'h12,  32'h0,        32'h0000BEEF, 1'b0, 2, 4,    32'hBEEF3344};
      vt[6]  = '{1'b0, 0,    32'h0,        1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 4,    32'hBEEF3344};
      vt[7]  = '{1'b1, 0,    32'h55667788, 1'b0, 3'd2, 32'h2,   32'h0,        32'h0,        1'b1, 1, 0,    32'h55667788};
      vt[8]  = '{1'b0, 0,    32'h0,        1'b1, 3'd1, 32'h1,   32'h0000FFFF, 32'h0,        1'b1, 1, 0,    32'h55667788};
      vt[9]  = '{1'b0, 0,    32'h0,        1'b0, 3'd2, 32'h1000,32'h0,        32'h0,        1'b1, 1, 4,    32'hBEEF3344};
      vt[10] = '{1'b0, 0,    32'h0,        1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1, 4,    32'hBEEF3344};
      vt[11] = '{1'b0, 0,    32'h0,        1'b1, 3'd3, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 4,    32'hBEEF3344};
      vt[12] = '{1'b1, 5,    32'h0,        1'b1, 3'd2, 32'h14,  32'hCAFEF00D, 32'h0,        1'b0, 3, 5,    32'hCAFEF00D};
      vt[13] = '{1'b0, 0,    32'h0,        1'b0, 3'd5, 32'h16,  32'h0,        32'h0000CAFE, 1'b0, 2, 5,    32'hCAFEF00D};
      vt[14] = '{1'b0, 0,    32'h0,        1'b0, 3'd0, 32'h15,  32'h0,        32'hFFFFFFF0, 1'b0, 2, 5,    32'hCAFEF00D};
      vt[15] = '{1'b1, 1023, 32'h01020304, 1'b0, 3'd2, 32'hFFC, 32'h0,        32'h01020304, 1'b0, 2, 1023, 32'h01020304};

      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;

      // Reset behaviour
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("post_rst_resp_rdata", resp_rdata, 32'd0);
      check("post_rst_resp_err", 32'(resp_err), 32'd0);
      check("post_rst_mem_addr", mem_addr, 32'd0);

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         if (vt[i].pre) mem[vt[i].pre_idx] = vt[i].pre_val;
         do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rdata, err, lat, wecnt);
         check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
         check($sformatf("vec%0d_mem_we_cycles", i), 32'(wecnt),
               (vt[i].we && !vt[i].exp_err) ? 32'd1 : 32'd0);
         @(negedge clk);
         check($sformatf("vec%0d_mem", i), mem[vt[i].mem_idx], vt[i].exp_mem);
      end

      // Reset during the WRITE cycle of SW 0x20
      mem[8] = 32'h0BADF00D;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h20; req_wdata = 32'h5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rstw_write_cycle_mem_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rstw_mem_we_gated", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstw_req_ready", 32'(req_ready), 32'd1);
      check("rstw_mem_addr", mem_addr, 32'd0);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      check("rstw_no_resp", 32'(seen), 32'd0);
      check("rstw_mem8", mem[8], 32'h0BADF00D);

      // Random traffic against the reference model
      for (int i = 0; i < 1024; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = 8'(w >> (8 * k));
      end
      for (int n = 0; n < 120; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
               case ($urandom_range(0, 4))
                  0: f3 = 3'd0;
                  1: f3 = 3'd1;
                  2: f3 = 3'd2;
                  3: f3 = 3'd4;
                  default: f3 = 3'd5;
               endcase
            end
         end
         if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(4088, 4200));
         else addr = 32'($urandom_range(0, 63));
         wdata = $urandom;
         ref_access(we, f3, addr, wdata, erd, eerr, elat);
         do_req(we, f3, addr, wdata, rdata, err, lat, wecnt);
         check($sformatf("rnd%0d_rdata", n), rdata, erd);
         check($sformatf("rnd%0d_err", n), 32'(err), 32'(eerr));
         check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
         check($sformatf("rnd%0d_mem_we_cycles", n), 32'(wecnt), (we && !eerr) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      for (int i = 0; i < 1024; i++) begin
         if (i < 16 || i >= 1020) begin
            w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            check($sformatf("rnd_mem_word%0d", i), mem[i], w);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
